// File: rtl/regfile_access_ctrl_if.sv
// Register-file access bundle: operand requests, operand return,
// writeback requests and the raw register-file port.
// The slave modport is the controller's view; master is the CPU/regfile side.
interface regfile_access_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 5,
   parameter int WB_DEPTH   = 4
);
   localparam int CNT_W = $clog2(WB_DEPTH) + 1;

   // operand request channel
   logic                  req_valid;
   logic                  req_ready;
   logic [SEL_WIDTH-1:0]  req_rs;
   logic [SEL_WIDTH-1:0]  req_rt;

   // operand return channel
   logic                  op_valid;
   logic                  op_ready;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;

   // writeback request channel
   logic                  wb_valid;
   logic                  wb_ready;
   logic [SEL_WIDTH-1:0]  wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  wb_hold;
   logic [CNT_W-1:0]      wb_pending;

   // register file port
   logic [SEL_WIDTH-1:0]  read_sel_1;
   logic [SEL_WIDTH-1:0]  read_sel_2;
   logic [DATA_WIDTH-1:0] read_data_1;
   logic [DATA_WIDTH-1:0] read_data_2;
   logic [SEL_WIDTH-1:0]  write_address;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  RegWrite;

   modport master (
      output req_valid, req_rs, req_rt, op_ready,
      output wb_valid, wb_addr, wb_data, wb_hold,
      output read_data_1, read_data_2,
      input  req_ready, op_valid, op_a, op_b, wb_ready, wb_pending,
      input  read_sel_1, read_sel_2, write_address, write_data, RegWrite
   );

   modport slave (
      input  req_valid, req_rs, req_rt, op_ready,
      input  wb_valid, wb_addr, wb_data, wb_hold,
      input  read_data_1, read_data_2,
      output req_ready, op_valid, op_a, op_b, wb_ready, wb_pending,
      output read_sel_1, read_sel_2, write_address, write_data, RegWrite
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller for the multicycle CPU.
// Sequences operand reads (IDLE -> READ -> HOLD) and drains a small
// writeback FIFO into the register file, stalling reads that would
// otherwise observe a register with a write still queued.
module regfile_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 5,
   parameter int WB_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_access_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                state;
   logic [SEL_WIDTH-1:0]  rs_q, rt_q;
   logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
   logic                  op_valid_q;

   logic [SEL_WIDTH-1:0]  fifo_addr [WB_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [WB_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;

   logic wb_ready_c, push, pop, reg_write_c, hazard, req_ready_c, req_fire;

   // True when a pending write to 'a' would be observed by a read of rs/rt.
   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic raw_hit(input logic [SEL_WIDTH-1:0] a,
                                    input logic [SEL_WIDTH-1:0] rs,
                                    input logic [SEL_WIDTH-1:0] rt);
      return (a != '0) && (((rs != '0) && (a == rs)) || ((rt != '0) && (a == rt)));
   endfunction

   // Handshake and drain qualifiers.
   always_comb begin
      wb_ready_c  = (count < CNT_W'(WB_DEPTH));
      push        = bus.wb_valid & wb_ready_c & (bus.wb_addr != '0);
      // Drain pauses in READ so the captured operands see a stable file.
      reg_write_c = (count != '0) & ~bus.wb_hold & (state != READ);
      pop         = reg_write_c;
   end

   // RAW check against every occupied FIFO slot (head included). A write
   // being pushed this same cycle also counts, otherwise a request issued
   // alongside its producer's writeback would read the stale value.
   always_comb begin
      logic [PTR_W-1:0] offs;
      hazard = 1'b0;
      offs   = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         offs = PTR_W'(i) - rd_ptr;
         if (({1'b0, offs} < count) && raw_hit(fifo_addr[i], bus.req_rs, bus.req_rt))
            hazard = 1'b1;
      end
      if (push && raw_hit(bus.wb_addr, bus.req_rs, bus.req_rt))
         hazard = 1'b1;
      req_ready_c = (state == IDLE) & ~hazard;
      req_fire    = bus.req_valid & req_ready_c;
   end

   // Read sequencer: latch selects, capture operands, hold until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rs_q       <= '0;
         rt_q       <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  rs_q  <= bus.req_rs;
                  rt_q  <= bus.req_rt;
                  state <= READ;
               end
            end
            READ: begin
               op_a_q     <= (rs_q == '0) ? '0 : bus.read_data_1;
               op_b_q     <= (rt_q == '0) ? '0 : bus.read_data_2;
               op_valid_q <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (bus.op_ready) begin
                  op_valid_q <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy; push and pop may share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.wb_addr;
         fifo_data[wr_ptr] <= bus.wb_data;
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.op_valid      = op_valid_q;
   assign bus.op_a          = op_a_q;
   assign bus.op_b          = op_b_q;
   assign bus.wb_ready      = wb_ready_c;
   assign bus.wb_pending    = count;
   assign bus.read_sel_1    = rs_q;
   assign bus.read_sel_2    = rt_q;
   assign bus.write_address = fifo_addr[rd_ptr];
   assign bus.write_data    = fifo_data[rd_ptr];
   assign bus.RegWrite      = reg_write_c;
endmodule
